// File: rtl/ram_if_pkg.sv
// Shared constants and FSM state type for the SRAM macro interfaces.
// Used by the write interface and its input FIFO.
package ram_if_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 16;
  localparam int CNT_W      = 4;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO, DEPTH x DW (DEPTH a power of 2), head always visible.
// Ports: clk, rst (sync, active-high), push/din, pop, head, full, empty.
module wr_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign head  = mem[rp];

  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO
  // still accepts a word while it is being drained.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ram_wr_interface.sv
// Burst write front-end: buffers 16-bit words and writes them to an SRAM macro.
// Ports: command (i_wr_ram/addr/wordcnt), data stream, status, CEN/WEN/A/D.
module ram_wr_interface
  import ram_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_ram,
  input  logic [ADDR_W-1:0] i_addr_ram,
  input  logic [CNT_W-1:0]  i_wordcnt_ram,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data_ram,
  output logic              o_fifo_full_ram,
  output logic              o_busy_ram,
  output logic              o_done_ram,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D
);

  state_t              state;
  state_t              state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [CNT_W-1:0]    rem_q;
  logic [DATA_W-1:0]   fifo_head;
  logic                fifo_empty;
  logic                issue;
  logic                accept;

  assign issue      = (state == WRITE) && !fifo_empty;
  assign accept     = (state == IDLE) && i_wr_ram;
  assign o_busy_ram = (state != IDLE);

  wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (i_data_valid),
    .din   (i_data_ram),
    .pop   (issue),
    .head  (fifo_head),
    .full  (o_fifo_full_ram),
    .empty (fifo_empty)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (i_wr_ram)
          state_n = (i_wordcnt_ram == '0) ? DONE : WRITE;
      end
      WRITE: begin
        if (issue && rem_q == CNT_W'(1))
          state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      CEN        <= 1'b1;
      WEN        <= 1'b1;
      A          <= '0;
      D          <= '0;
      o_done_ram <= 1'b0;
    end else begin
      state      <= state_n;
      o_done_ram <= (state == DONE);
      CEN        <= !issue;
      WEN        <= !issue;
      // A/D only move on a real write; they hold otherwise.
      if (issue) begin
        A      <= addr_q;
        D      <= fifo_head;
        addr_q <= addr_q + 1'b1;
        rem_q  <= rem_q - 1'b1;
      end
      if (accept) begin
        addr_q <= i_addr_ram;
        rem_q  <= i_wordcnt_ram;
      end
    end
  end

endmodule

// File: tb/tb_ram_wr_interface.sv
// Self-checking bench for ram_wr_interface: vector table, directed
// corner cases and random traffic against a queue-based reference.
module tb_ram_wr_interface;
  import ram_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [6:0]  addr = '0;
  logic [3:0]  cnt = '0;
  logic        valid = 1'b0;
  logic [15:0] data = '0;
  logic        full, busy, done, cen, wen;
  logic [6:0]  a;
  logic [15:0] d;

  always #5 clk = ~clk;

  ram_wr_interface dut (
    .clk             (clk),
    .rst             (rst),
    .i_wr_ram        (wr),
    .i_addr_ram      (addr),
    .i_wordcnt_ram   (cnt),
    .i_data_valid    (valid),
    .i_data_ram      (data),
    .o_fifo_full_ram (full),
    .o_busy_ram      (busy),
    .o_done_ram      (done),
    .CEN             (cen),
    .WEN             (wen),
    .A               (a),
    .D               (d)
  );

  int checks = 0;
  int errors = 0;

  // reference model: buffered words, burst phase 0 idle/1 writing/2 done
  int          q[$];
  int          phase = 0;
  logic [6:0]  maddr = '0;
  int          mrem = 0;
  logic        e_cen = 1'b1;
  logic        e_wen = 1'b1;
  logic        e_done = 1'b0;
  logic [6:0]  e_a = '0;
  logic [15:0] e_d = '0;

  logic [15:0] mac [128];
  logic [6:0]  wa[$];
  logic [15:0] wd[$];
  int          ndone = 0;

  typedef struct {
    logic rst; logic wr; logic [6:0] addr; logic [3:0] cnt;
    logic valid; logic [15:0] data;
    logic cen; logic wen; logic [6:0] a; logic [15:0] d;
    logic done; logic busy; logic full;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop;
    bit was_full;
    if (rst) begin
      q.delete();
      phase = 0; maddr = '0; mrem = 0;
      e_cen = 1; e_wen = 1; e_a = '0; e_d = '0; e_done = 0;
      return;
    end
    pop = (phase == 1) && (q.size() > 0);
    was_full = (q.size() == FIFO_DEPTH);
    e_done = (phase == 2);
    e_cen = !pop;
    e_wen = !pop;
    if (pop) begin
      e_a = maddr;
      e_d = 16'(q[0]);
      void'(q.pop_front());
    end
    if (valid && (!was_full || pop)) q.push_back(int'(data));
    case (phase)
      0: if (wr) begin
        maddr = addr; mrem = int'(cnt);
        phase = (cnt == 0) ? 2 : 1;
      end
      1: if (pop) begin
        maddr = maddr + 7'd1;
        mrem--;
        if (mrem == 0) phase = 2;
      end
      default: phase = 0;
    endcase
  endtask

  task automatic log_w();
    if (cen === 1'b0 && wen === 1'b0) begin
      mac[a] = d;
      wa.push_back(a);
      wd.push_back(d);
    end
    if (done === 1'b1) ndone++;
  endtask

  task automatic check_all();
    chk("cen", cen, e_cen);
    chk("wen", wen, e_wen);
    chk("addr", a, e_a);
    chk("data", d, e_d);
    chk("done", done, e_done);
    chk("busy", busy, phase != 0);
    chk("full", full, q.size() == FIFO_DEPTH);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    log_w();
    check_all();
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); ndone = 0;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1; data = 16'(base + i);
      tick();
    end
    valid = 0;
  endtask

  task automatic cmd(input logic [6:0] ad, input logic [3:0] c);
    wr = 1; addr = ad; cnt = c;
    tick();
    wr = 0;
  endtask

  initial begin
    //        rst wr addr  cnt vld data      cen wen a     d        dn by fl
    tv[0]  = '{1, 0, 7'h0, 0, 0, 16'h0,     1, 1, 7'h0, 16'h0,    0, 0, 0};
    tv[1]  = '{0, 0, 7'h0, 0, 1, 16'hA1A1,  1, 1, 7'h0, 16'h0,    0, 0, 0};
    tv[2]  = '{0, 0, 7'h0, 0, 1, 16'hB2B2,  1, 1, 7'h0, 16'h0,    0, 0, 0};
    tv[3]  = '{0, 0, 7'h0, 0, 1, 16'hC3C3,  1, 1, 7'h0, 16'h0,    0, 0, 0};
    tv[4]  = '{0, 0, 7'h0, 0, 1, 16'hD4D4,  1, 1, 7'h0, 16'h0,    0, 0, 1};
    tv[5]  = '{0, 1, 7'h01, 4, 0, 16'h0,    1, 1, 7'h0, 16'h0,    0, 1, 1};
    tv[6]  = '{0, 0, 7'h0, 0, 0, 16'h0,     0, 0, 7'h01, 16'hA1A1, 0, 1, 0};
    tv[7]  = '{0, 0, 7'h0, 0, 0, 16'h0,     0, 0, 7'h02, 16'hB2B2, 0, 1, 0};
    tv[8]  = '{0, 0, 7'h0, 0, 0, 16'h0,     0, 0, 7'h03, 16'hC3C3, 0, 1, 0};
    tv[9]  = '{0, 0, 7'h0, 0, 0, 16'h0,     0, 0, 7'h04, 16'hD4D4, 0, 1, 0};
    tv[10] = '{0, 0, 7'h0, 0, 0, 16'h0,     1, 1, 7'h04, 16'hD4D4, 1, 0, 0};
    tv[11] = '{0, 0, 7'h0, 0, 0, 16'h0,     1, 1, 7'h04, 16'hD4D4, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      rst = tv[i].rst; wr = tv[i].wr; addr = tv[i].addr;
      cnt = tv[i].cnt; valid = tv[i].valid; data = tv[i].data;
      @(posedge clk);
      model_step();
      @(negedge clk);
      log_w();
      chk($sformatf("tv%0d_cen", i), cen, tv[i].cen);
      chk($sformatf("tv%0d_wen", i), wen, tv[i].wen);
      chk($sformatf("tv%0d_a", i), a, tv[i].a);
      chk($sformatf("tv%0d_d", i), d, tv[i].d);
      chk($sformatf("tv%0d_done", i), done, tv[i].done);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("tv%0d_full", i), full, tv[i].full);
    end
    chk("readback1", mac[1], 16'hA1A1);
    chk("readback2", mac[2], 16'hB2B2);
    chk("readback3", mac[3], 16'hC3C3);
    chk("readback4", mac[4], 16'hD4D4);

    // stalled burst, plus a request while busy that must be ignored
    clr();
    cmd(7'h10, 4'd3);
    for (int i = 0; i < 3; i++) begin
      valid = 1; data = 16'(16'h1000 + i);
      tick();
      valid = 0;
      if (i == 1) begin wr = 1; addr = 7'h55; cnt = 4'd2; end
      tick();
      wr = 0;
      tick();
    end
    repeat (2) tick();
    chk("stall_nwr", wa.size(), 3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      chk("stall_addr", wa[i], 7'h10 + 7'(i));
      chk("stall_data", wd[i], 16'h1000 + 16'(i));
    end
    chk("stall_done", ndone, 1);

    // address wrap
    clr();
    push_words(16'h3000, 4);
    cmd(7'h7E, 4'd4);
    repeat (6) tick();
    chk("wrap_nwr", wa.size(), 4);
    if (wa.size() == 4) begin
      chk("wrap_a0", wa[0], 7'h7E);
      chk("wrap_a1", wa[1], 7'h7F);
      chk("wrap_a2", wa[2], 7'h00);
      chk("wrap_a3", wa[3], 7'h01);
    end

    // zero-length burst
    clr();
    cmd(7'h05, 4'd0);
    chk("cnt0_busy", busy, 1);
    chk("cnt0_done_early", done, 0);
    tick();
    chk("cnt0_done", done, 1);
    chk("cnt0_idle", busy, 0);
    tick();
    chk("cnt0_done_end", done, 0);
    chk("cnt0_nwr", wa.size(), 0);

    // overfill: 5th word dropped
    clr();
    for (int i = 0; i < 5; i++) begin
      valid = 1; data = 16'(16'h4000 + i);
      tick();
      if (i == 3) chk("ovf_full4", full, 1);
    end
    valid = 0;
    chk("ovf_full5", full, 1);
    cmd(7'h30, 4'd4);
    repeat (6) tick();
    chk("ovf_nwr", wa.size(), 4);
    for (int i = 0; i < 4 && i < wd.size(); i++)
      chk("ovf_data", wd[i], 16'h4000 + 16'(i));
    chk("ovf_notfull", full, 0);
    clr();
    cmd(7'h40, 4'd1);
    repeat (3) tick();
    chk("ovf_dropped", wa.size(), 0);
    push_words(16'h4444, 1);
    repeat (3) tick();
    chk("ovf_late_nwr", wa.size(), 1);
    if (wd.size() > 0) chk("ovf_late_data", wd[0], 16'h4444);

    // reset in the middle of a burst
    clr();
    push_words(16'h5000, 4);
    cmd(7'h50, 4'd4);
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_cen", cen, 1);
    chk("rst_wen", wen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    repeat (4) tick();
    chk("rst_nodone", ndone, 0);
    chk("rst_nwr", wa.size(), 1);
    clr();
    push_words(16'h6000, 2);
    cmd(7'h20, 4'd2);
    repeat (4) tick();
    chk("post_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("post_a0", wa[0], 7'h20);
      chk("post_a1", wa[1], 7'h21);
      chk("post_d0", wd[0], 16'h6000);
      chk("post_d1", wd[1], 16'h6001);
    end
    chk("post_done", ndone, 1);

    // random traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      wr    = ($urandom_range(0, 7) == 0);
      addr  = 7'($urandom);
      cnt   = 4'($urandom);
      valid = 1'($urandom_range(0, 1));
      data  = 16'($urandom);
      tick();
    end
    rst = 0; wr = 0; valid = 0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
